// File: rtl/fb_pkg.sv
// Shared constants and encodings for the framebuffer write arbiter slice.
// Frame geometry is expressed as blocks of pixels as delivered by the SD loader.
package fb_pkg;

    localparam int ADDR_W           = 17;
    localparam int DATA_W           = 16;
    localparam int BLOCKS_PER_IMAGE = 300;
    localparam int PIXELS_PER_BLOCK = 256;
    localparam int FB_PIXELS        = BLOCKS_PER_IMAGE * PIXELS_PER_BLOCK;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    typedef enum logic {
        SD   = 1'b0,
        DRAW = 1'b1
    } fb_grant_t;

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-way round-robin grant between the SD loader and the draw port.
// The grant history only advances on an actual transfer.
module fb_rr_arb2
    import fb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sd_valid,
    input  logic draw_valid,
    output logic sd_ready,
    output logic draw_ready
);

    fb_grant_t last_grant;

    // Starting from DRAW makes SD the winner of the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= DRAW;
        end else if (sd_ready) begin
            last_grant <= SD;
        end else if (draw_ready) begin
            last_grant <= DRAW;
        end
    end

    assign sd_ready   = enable & sd_valid & (~draw_valid | (last_grant == DRAW));
    assign draw_ready = enable & draw_valid & (~sd_valid | (last_grant == SD));

endmodule

// File: rtl/fb_write_arbiter.sv
// Sole owner of the framebuffer write port: arbitrates SD and draw writes and
// runs the full-frame clear engine, registering one write per cycle.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int              ADDR_W      = fb_pkg::ADDR_W,
    parameter int              DATA_W      = fb_pkg::DATA_W,
    parameter int              FB_PIXELS   = fb_pkg::FB_PIXELS,
    parameter logic [15:0]     CLEAR_COLOR = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sd_valid,
    output logic              sd_ready,
    input  logic [ADDR_W-1:0] sd_addr,
    input  logic [DATA_W-1:0] sd_data,
    input  logic              draw_valid,
    output logic              draw_ready,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_data,
    output logic [7:0]        drop_count
);

    localparam int                CNT_W    = (FB_PIXELS > 1) ? $clog2(FB_PIXELS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FB_PIXELS - 1);
    localparam logic [ADDR_W:0]   FB_LIMIT = (ADDR_W + 1)'(FB_PIXELS);

    fb_state_t         state;
    fb_state_t         state_next;
    logic [CNT_W-1:0]  clr_cnt;
    logic              arb_en;
    logic              clr_last;
    logic              wr_xfer;
    logic              wr_in_range;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    fb_rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .reset      (reset),
        .enable     (arb_en),
        .sd_valid   (sd_valid),
        .draw_valid (draw_valid),
        .sd_ready   (sd_ready),
        .draw_ready (draw_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB:     if (clear_req) state_next = CLEAR;
            CLEAR:   if (clr_last)  state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    // clear_req blocks both requesters in the very cycle it is seen, so no
    // requester write can land between the request and the first clear write.
    always_comb begin
        clear_busy = (state == CLEAR);
        arb_en     = (state == ARB) & ~clear_req;
        clr_last   = (state == CLEAR) & (clr_cnt == CNT_LAST);
    end

    always_comb begin
        wr_xfer     = sd_ready | draw_ready;
        wr_addr     = sd_ready ? sd_addr : draw_addr;
        wr_data     = sd_ready ? sd_data : draw_data;
        wr_in_range = ({1'b0, wr_addr} < FB_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt    <= '0;
            clear_done <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            drop_count <= '0;
        end else begin
            clear_done <= clr_last;
            if (state == CLEAR) begin
                fb_we   <= 1'b1;
                fb_addr <= ADDR_W'(clr_cnt);
                fb_data <= DATA_W'(CLEAR_COLOR);
                clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
                fb_we   <= wr_xfer & wr_in_range;
                if (wr_xfer & wr_in_range) begin
                    fb_addr <= wr_addr;
                    fb_data <= wr_data;
                end
                // Out-of-range writes are accepted so the requester never stalls.
                if (wr_xfer & ~wr_in_range & (drop_count != 8'hFF)) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter with a 16-pixel frame, compared
// against a cycle-level behavioural model of the write port.
module tb_fb_write_arbiter;

    localparam int FBP = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        sd_valid, draw_valid, clear_req;
    logic        sd_ready, draw_ready;
    logic [16:0] sd_addr, draw_addr;
    logic [15:0] sd_data, draw_data;
    logic        clear_busy, clear_done, fb_we;
    logic [16:0] fb_addr;
    logic [15:0] fb_data;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;

    // behavioural model of the externally visible port state
    bit          m_clearing, m_done, m_we, m_last_sd;
    int          m_idx, m_drops;
    logic [16:0] m_addr;
    logic [15:0] m_data;

    fb_write_arbiter #(.FB_PIXELS(FBP)) dut (
        .clk(clk), .reset(reset),
        .sd_valid(sd_valid), .sd_ready(sd_ready), .sd_addr(sd_addr), .sd_data(sd_data),
        .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_addr(draw_addr), .draw_data(draw_data),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_clearing = 0; m_done = 0; m_we = 0; m_last_sd = 0;
        m_idx = 0; m_drops = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; sd_valid = 0; draw_valid = 0; clear_req = 0;
        sd_addr = '0; sd_data = '0; draw_addr = '0; draw_data = '0;
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, capture readies, advance model, return after the edge.
    task automatic step(input bit sv, input logic [16:0] sa, input logic [15:0] sdd,
                        input bit dv, input logic [16:0] da, input logic [15:0] ddd,
                        input bit cr, output bit o_sr, output bit o_dr,
                        output bit e_sr, output bit e_dr);
        logic [16:0] wa;
        logic [15:0] wd;
        @(negedge clk);
        sd_valid = sv; sd_addr = sa; sd_data = sdd;
        draw_valid = dv; draw_addr = da; draw_data = ddd;
        clear_req = cr;
        #1;
        o_sr = sd_ready;
        o_dr = draw_ready;
        e_sr = !m_clearing && !cr && sv && (!dv || !m_last_sd);
        e_dr = !m_clearing && !cr && dv && (!sv || m_last_sd);
        m_done = 0;
        if (m_clearing) begin
            m_we = 1; m_addr = 17'(m_idx); m_data = 16'h0000;
            if (m_idx == FBP - 1) begin
                m_clearing = 0; m_idx = 0; m_done = 1;
            end else begin
                m_idx++;
            end
        end else if (cr) begin
            m_we = 0; m_clearing = 1; m_idx = 0;
        end else if (e_sr || e_dr) begin
            wa = e_sr ? sa : da;
            wd = e_sr ? sdd : ddd;
            m_last_sd = e_sr;
            if (int'(wa) < FBP) begin
                m_we = 1; m_addr = wa; m_data = wd;
            end else begin
                m_we = 0;
                if (m_drops < 255) m_drops++;
            end
        end else begin
            m_we = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit o_sr, o_dr, e_sr, e_dr;
        do_reset();
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", fb_we); end
        checks++; if (fb_addr !== '0 || fb_data !== '0) begin errors++; $display("FAIL reset_addr_data got=%h/%h want=0/0", fb_addr, fb_data); end
        checks++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear got busy=%b done=%b want 0/0", clear_busy, clear_done); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drops got=%0d want=0", drop_count); end
        step(0, 0, 0, 0, 0, 0, 0, o_sr, o_dr, e_sr, e_dr);
        checks++; if (o_sr !== 1'b0 || o_dr !== 1'b0) begin errors++; $display("FAIL reset_idle_ready got=%b%b want=00", o_sr, o_dr); end
    endtask

    task automatic test_sd_only();
        bit o_sr, o_dr, e_sr, e_dr;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 17'(i), 16'hA000 + 16'(i), 0, 0, 0, 0, o_sr, o_dr, e_sr, e_dr);
            checks++; if (o_sr !== 1'b1 || o_dr !== 1'b0) begin errors++; $display("FAIL sd_only_ready[%0d] got sd=%b draw=%b want sd=1 draw=0", i, o_sr, o_dr); end
            checks++; if (fb_we !== 1'b1 || fb_addr !== 17'(i) || fb_data !== 16'hA000 + 16'(i)) begin
                errors++; $display("FAIL sd_only_write[%0d] got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", i, fb_we, fb_addr, fb_data, i, 16'hA000 + 16'(i));
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, o_sr, o_dr, e_sr, e_dr);
        checks++; if (fb_we !== 1'b0 || fb_addr !== 17'd3 || fb_data !== 16'hA003) begin
            errors++; $display("FAIL sd_only_hold got we=%b addr=%0d data=%h want we=0 addr=3 data=a003", fb_we, fb_addr, fb_data);
        end
    endtask

    task automatic test_round_robin();
        bit o_sr, o_dr, e_sr, e_dr;
        logic [16:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 17'd5, 16'h5555, 1, 17'd9, 16'h9999, 0, o_sr, o_dr, e_sr, e_dr);
            want = (i % 2 == 0) ? 17'd5 : 17'd9;
            checks++; if (o_sr !== e_sr || o_dr !== e_dr || o_sr !== (i % 2 == 0)) begin
                errors++; $display("FAIL rr_grant[%0d] got sd=%b draw=%b want sd=%b draw=%b", i, o_sr, o_dr, e_sr, e_dr);
            end
            checks++; if (fb_we !== 1'b1 || fb_addr !== want) begin
                errors++; $display("FAIL rr_write[%0d] got we=%b addr=%0d want we=1 addr=%0d", i, fb_we, fb_addr, want);
            end
        end
    endtask

    task automatic test_clear();
        bit o_sr, o_dr, e_sr, e_dr;
        int done_cnt, done_at, bad;
        done_cnt = 0; done_at = -1; bad = 0;
        step(1, 17'd2, 16'h1111, 1, 17'd4, 16'h2222, 1, o_sr, o_dr, e_sr, e_dr);
        checks++; if (o_sr !== 1'b0 || o_dr !== 1'b0 || clear_busy !== 1'b1) begin
            errors++; $display("FAIL clear_start got ready=%b%b busy=%b want ready=00 busy=1", o_sr, o_dr, clear_busy);
        end
        for (int k = 1; k <= 19; k++) begin
            step(1, 17'd2, 16'h1111, 1, 17'd4, 16'h2222, 0, o_sr, o_dr, e_sr, e_dr);
            if (clear_done === 1'b1) begin done_cnt++; done_at = k; end
            if (o_sr !== e_sr || o_dr !== e_dr || clear_busy !== m_clearing || clear_done !== m_done ||
                fb_we !== m_we || fb_addr !== m_addr || fb_data !== m_data) begin
                bad++;
                $display("FAIL clear_cycle[%0d] got rdy=%b%b busy=%b done=%b we=%b addr=%0d data=%h want rdy=%b%b busy=%b done=%b we=%b addr=%0d data=%h",
                         k, o_sr, o_dr, clear_busy, clear_done, fb_we, fb_addr, fb_data,
                         e_sr, e_dr, m_clearing, m_done, m_we, m_addr, m_data);
            end
            if (k == 16 && (fb_addr !== 17'(FBP - 1) || fb_data !== 16'h0000)) begin
                bad++; $display("FAIL clear_last_addr got addr=%0d data=%h want addr=%0d data=0000", fb_addr, fb_data, FBP - 1);
            end
        end
        checks++; if (bad != 0) errors++;
        checks++; if (done_cnt != 1 || done_at != 16) begin
            errors++; $display("FAIL clear_done_pulse got count=%0d at=%0d want count=1 at=16", done_cnt, done_at);
        end
    endtask

    task automatic test_drops();
        bit o_sr, o_dr, e_sr, e_dr;
        do_reset();
        step(1, 17'd16, 16'hBEEF, 0, 0, 0, 0, o_sr, o_dr, e_sr, e_dr);
        checks++; if (o_sr !== 1'b1 || fb_we !== 1'b0) begin errors++; $display("FAIL drop_16 got ready=%b we=%b want ready=1 we=0", o_sr, fb_we); end
        step(1, 17'd20, 16'hCAFE, 0, 0, 0, 0, o_sr, o_dr, e_sr, e_dr);
        checks++; if (o_sr !== 1'b1 || fb_we !== 1'b0 || drop_count !== 8'd2) begin
            errors++; $display("FAIL drop_20 got ready=%b we=%b drops=%0d want ready=1 we=0 drops=2", o_sr, fb_we, drop_count);
        end
        for (int i = 0; i < 300; i++) begin
            step(1, 17'($urandom_range(FBP, 131071)), 16'($urandom), 0, 0, 0, 0, o_sr, o_dr, e_sr, e_dr);
        end
        checks++; if (drop_count !== 8'd255 || int'(drop_count) != m_drops) begin
            errors++; $display("FAIL drop_saturate got=%0d want=255", drop_count);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit o_sr, o_dr, e_sr, e_dr;
        int done_seen;
        done_seen = 0;
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1, o_sr, o_dr, e_sr, e_dr);
        for (int k = 0; k < 7; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, o_sr, o_dr, e_sr, e_dr);
            if (clear_done === 1'b1) done_seen++;
        end
        checks++; if (clear_busy !== 1'b1 || fb_addr !== 17'd6) begin
            errors++; $display("FAIL midclear_progress got busy=%b addr=%0d want busy=1 addr=6", clear_busy, fb_addr);
        end
        @(negedge clk);
        reset = 1;
        #1;
        checks++; if (fb_we !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
            errors++; $display("FAIL midclear_abort got we=%b busy=%b done=%b want 0/0/0", fb_we, clear_busy, clear_done);
        end
        @(negedge clk);
        if (clear_done === 1'b1) done_seen++;
        reset = 0;
        model_reset();
        step(1, 17'd3, 16'h0333, 0, 0, 0, 0, o_sr, o_dr, e_sr, e_dr);
        if (clear_done === 1'b1) done_seen++;
        checks++; if (fb_we !== 1'b1 || fb_addr !== 17'd3 || fb_data !== 16'h0333 || done_seen != 0) begin
            errors++; $display("FAIL midclear_resume got we=%b addr=%0d data=%h dones=%0d want we=1 addr=3 data=0333 dones=0", fb_we, fb_addr, fb_data, done_seen);
        end
    endtask

    task automatic test_clear_held();
        bit o_sr, o_dr, e_sr, e_dr;
        int grants, dones, bad;
        grants = 0; dones = 0; bad = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1, 17'd1, 16'h0101, 1, 17'd2, 16'h0202, (i < 20), o_sr, o_dr, e_sr, e_dr);
            if (i < 33 && (o_sr || o_dr)) grants++;
            if (clear_done === 1'b1) dones++;
            if (o_sr !== e_sr || o_dr !== e_dr || clear_busy !== m_clearing || clear_done !== m_done ||
                fb_we !== m_we || fb_addr !== m_addr) begin
                bad++;
                $display("FAIL held_cycle[%0d] got rdy=%b%b busy=%b done=%b we=%b addr=%0d want rdy=%b%b busy=%b done=%b we=%b addr=%0d",
                         i, o_sr, o_dr, clear_busy, clear_done, fb_we, fb_addr, e_sr, e_dr, m_clearing, m_done, m_we, m_addr);
            end
        end
        checks++; if (bad != 0) errors++;
        checks++; if (grants != 0 || dones != 2) begin
            errors++; $display("FAIL held_summary got grants=%0d dones=%0d want grants=0 dones=2", grants, dones);
        end
    endtask

    task automatic test_random();
        bit o_sr, o_dr, e_sr, e_dr;
        bit sv, dv, cr;
        logic [16:0] sa, da;
        logic [15:0] sdd, ddd;
        int bad;
        bad = 0; sv = 0; dv = 0; sa = 0; da = 0; sdd = 0; ddd = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!sv || o_sr) begin
                sv = ($urandom_range(0, 3) != 0); sa = 17'($urandom_range(0, 23)); sdd = 16'($urandom);
            end
            if (!dv || o_dr) begin
                dv = ($urandom_range(0, 2) != 0); da = 17'($urandom_range(0, 23)); ddd = 16'($urandom);
            end
            cr = ($urandom_range(0, 59) == 0);
            step(sv, sa, sdd, dv, da, ddd, cr, o_sr, o_dr, e_sr, e_dr);
            if (o_sr !== e_sr || o_dr !== e_dr || clear_busy !== m_clearing || clear_done !== m_done ||
                fb_we !== m_we || fb_addr !== m_addr || fb_data !== m_data || int'(drop_count) != m_drops) begin
                bad++;
                $display("FAIL random[%0d] got rdy=%b%b busy=%b we=%b addr=%0d data=%h drops=%0d want rdy=%b%b busy=%b we=%b addr=%0d data=%h drops=%0d",
                         i, o_sr, o_dr, clear_busy, fb_we, fb_addr, fb_data, drop_count,
                         e_sr, e_dr, m_clearing, m_we, m_addr, m_data, m_drops);
            end
        end
        checks++; if (bad != 0) errors++;
    endtask

    initial begin
        reset = 1; sd_valid = 0; draw_valid = 0; clear_req = 0;
        sd_addr = '0; sd_data = '0; draw_addr = '0; draw_data = '0;
        model_reset();
        test_reset();
        test_sd_only();
        test_round_robin();
        test_clear();
        test_drops();
        test_reset_mid_clear();
        test_clear_held();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
